// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int          DEF_NREQ     = 4;
  localparam int          DEF_MAX_PKT  = 16;
  localparam int          DEF_HOLD_TO  = 64;
  localparam logic [15:0] DEF_BAUD_DIV = 16'd434;

  // Next requester index after v, wrapping at n.
  function automatic logic [2:0] wrap_inc(input logic [2:0] v, input int n);
    if (int'(v) >= n - 1) return 3'd0;
    return v + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      rr_ptr,
  output logic            found,
  output logic [2:0]      index
);

  logic [7:0]      req_ext;
  logic [2:0]      cand [NREQ];
  logic [NREQ-1:0] hit;

  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req;
  end

  // cand[k] is the k-th index visited starting from rr_ptr.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [3:0] sum;
    assign sum       = {1'b0, rr_ptr} + 4'(gi);
    assign cand[gi]  = (sum >= 4'(NREQ)) ? 3'(sum - 4'(NREQ)) : sum[2:0];
    assign hit[gi]   = req_ext[cand[gi]];
  end

  always_comb begin
    found = 1'b0;
    index = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        found = 1'b1;
        index = cand[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one requester at a time a packet-locked path to a UART.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          NREQ     = DEF_NREQ,
  parameter logic [15:0] BAUD_DIV = DEF_BAUD_DIV,
  parameter int          MAX_PKT  = DEF_MAX_PKT,
  parameter int          HOLD_TO  = DEF_HOLD_TO
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              grant_valid,
  output logic [2:0]        grant_id,
  output logic              pkt_abort,
  output logic [7:0]        uart_tx_reg,
  output logic              uart_tx_on,
  input  logic              uart_tx_busy,
  output logic [7:0]        uart_baud_regl,
  output logic [7:0]        uart_baud_regh
);

  localparam int BCW = $clog2(MAX_PKT + 1);
  localparam int HCW = $clog2(HOLD_TO + 1);

  arb_state_e     state_q, state_d;
  logic           grant_valid_q, grant_valid_d;
  logic [2:0]     grant_id_q, grant_id_d;
  logic [2:0]     rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           last_q, last_d;
  logic [7:0]     tx_reg_q, tx_reg_d;
  logic           tx_on_q, tx_on_d;
  logic           abort_q, abort_d;

  logic [7:0]  valid_ext;
  logic [7:0]  last_ext;
  logic [63:0] data_ext;
  logic        cur_valid;
  logic        cur_last;
  logic [7:0]  cur_data;
  logic        pick_found;
  logic [2:0]  pick_idx;
  logic        release_now;

  always_comb begin
    valid_ext                 = '0;
    last_ext                  = '0;
    data_ext                  = '0;
    valid_ext[NREQ-1:0]       = req_valid;
    last_ext[NREQ-1:0]        = req_last;
    data_ext[8*NREQ-1:0]      = req_data;
  end

  assign cur_valid = valid_ext[grant_id_q];
  assign cur_last  = last_ext[grant_id_q];
  assign cur_data  = data_ext[{grant_id_q, 3'b000} +: 8];

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .index  (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    byte_cnt_d    = byte_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    last_d        = last_q;
    tx_reg_d      = tx_reg_q;
    tx_on_d       = 1'b0;
    abort_d       = 1'b0;
    release_now   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_valid_d = 1'b1;
          grant_id_d    = pick_idx;
          byte_cnt_d    = '0;
          hold_cnt_d    = '0;
          state_d       = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cur_valid) begin
          tx_reg_d   = cur_data;
          last_d     = cur_last;
          tx_on_d    = 1'b1;
          hold_cnt_d = '0;
          if (byte_cnt_q != BCW'(MAX_PKT)) byte_cnt_d = byte_cnt_q + BCW'(1);
          state_d    = ST_WAIT_BUSY;
        end else if (hold_cnt_q >= HCW'(HOLD_TO - 1)) begin
          // This idle cycle brings the hold count to HOLD_TO: give up the packet.
          hold_cnt_d  = HCW'(HOLD_TO);
          abort_d     = 1'b1;
          release_now = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      ST_WAIT_BUSY: begin
        if (uart_tx_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (last_q || (byte_cnt_q == BCW'(MAX_PKT))) release_now = 1'b1;
          else                                          state_d     = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Releasing always passes through IDLE, so a new grant waits one cycle.
    if (release_now) begin
      state_d       = ST_IDLE;
      grant_valid_d = 1'b0;
      rr_ptr_d      = wrap_inc(grant_id_q, NREQ);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= 3'd0;
      rr_ptr_q      <= 3'd0;
      byte_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      last_q        <= 1'b0;
      tx_reg_q      <= 8'h00;
      tx_on_q       <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      byte_cnt_q    <= byte_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      last_q        <= last_d;
      tx_reg_q      <= tx_reg_d;
      tx_on_q       <= tx_on_d;
      abort_q       <= abort_d;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = (state_q == ST_SEND) && (grant_id_q == 3'(gi));
  end

  assign grant_valid    = grant_valid_q;
  assign grant_id       = grant_id_q;
  assign pkt_abort      = abort_q;
  assign uart_tx_reg    = tx_reg_q;
  assign uart_tx_on     = tx_on_q;
  assign uart_baud_regl = BAUD_DIV[7:0];
  assign uart_baud_regh = BAUD_DIV[15:8];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: grant order, packet lock, MAX_PKT, hold timeout, reset.
module tb_uart_tx_arbiter;

  localparam int          NREQ     = 4;
  localparam int          MAX_PKT  = 4;
  localparam int          HOLD_TO  = 64;
  localparam logic [15:0] BAUD     = 16'h1B2C;
  localparam int          BUSY_CYC = 5;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] d;
  } exp_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } byte_t;

  logic              clk;
  logic              resetn;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              grant_valid;
  logic [2:0]        grant_id;
  logic              pkt_abort;
  logic [7:0]        uart_tx_reg;
  logic              uart_tx_on;
  logic              uart_tx_busy;
  logic [7:0]        uart_baud_regl;
  logic [7:0]        uart_baud_regh;

  int    check_cnt = 0;
  int    fail_cnt  = 0;
  int    idle_cnt  = 0;
  int    abort_hi  = 0;
  int    abort_rise = 0;
  exp_t  sb_q [$];
  byte_t src_q [NREQ][$];

  uart_tx_arbiter #(
    .NREQ     (NREQ),
    .BAUD_DIV (BAUD),
    .MAX_PKT  (MAX_PKT),
    .HOLD_TO  (HOLD_TO)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id),
    .pkt_abort      (pkt_abort),
    .uart_tx_reg    (uart_tx_reg),
    .uart_tx_on     (uart_tx_on),
    .uart_tx_busy   (uart_tx_busy),
    .uart_baud_regl (uart_baud_regl),
    .uart_baud_regh (uart_baud_regh)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic load(input int id, input logic [7:0] d, input logic l);
    byte_t b;
    b.d = d;
    b.l = l;
    src_q[id].push_back(b);
  endtask

  task automatic expect_tx(input logic [2:0] id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.d  = d;
    sb_q.push_back(e);
  endtask

  // UART stand-in: pops the scoreboard on every strobe, then runs a busy frame.
  task automatic uart_model();
    exp_t       e;
    bit         rst_seen;
    logic [7:0] sent;
    uart_tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (uart_tx_on === 1'b1) begin
        sent = uart_tx_reg;
        $display("tx grant=%0d data=%02h t=%0t", grant_id, uart_tx_reg, $time);
        check_val("sb_nonempty", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_val("tx_id_data", {grant_valid, grant_id, uart_tx_reg}, {1'b1, e.id, e.d});
        end
        @(posedge clk); #1;
        check_val("tx_on_pulse", uart_tx_on, 0);
        uart_tx_busy = 1'b1;
        rst_seen = 1'b0;
        repeat (BUSY_CYC) begin
          @(posedge clk); #1;
          if (!resetn) rst_seen = 1'b1;
        end
        if (!rst_seen) check_val("tx_reg_hold", uart_tx_reg, sent);
        uart_tx_busy = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    logic abort_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (|(req_ready & ~req_valid)) idle_cnt++;
      if (pkt_abort === 1'b1) begin
        abort_hi++;
        if (!abort_prev) abort_rise++;
      end
      abort_prev = pkt_abort;
    end
  endtask

  task automatic reset_dut();
    resetn    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_release(input int budget);
    int cyc = 0;
    while ((grant_valid || uart_tx_busy) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("wait_release", {grant_valid, uart_tx_busy}, 2'b00);
  endtask

  // Presents every queued byte on its requester and retires it on handshake.
  task automatic run_traffic(input int budget);
    int              cyc = 0;
    logic [NREQ-1:0] acc;
    bit              done = 0;
    while (!done && cyc < budget) begin
      for (int i = 0; i < NREQ; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = src_q[i][0].d;
          req_last[i]        = src_q[i][0].l;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < NREQ; i++)
        if (acc[i]) void'(src_q[i].pop_front());
      done = (src_q[0].size() == 0) && (src_q[1].size() == 0) && (src_q[2].size() == 0) &&
             (src_q[3].size() == 0) && (sb_q.size() == 0) && !grant_valid && !uart_tx_busy;
    end
    req_valid = '0;
    req_last  = '0;
    check_val("traffic_done", 32'(done), 1);
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int idle0;
    int rise0;
    int hi0;
    resetn    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fork
      uart_model();
      monitor();
      begin
        #2_000_000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_grant_valid", grant_valid, 0);
    check_val("rst_grant_id", grant_id, 0);
    check_val("rst_pkt_abort", pkt_abort, 0);
    check_val("rst_tx_on", uart_tx_on, 0);
    check_val("rst_tx_reg", uart_tx_reg, 8'h00);
    check_val("rst_req_ready", req_ready, 0);
    check_val("baud_regl", uart_baud_regl, 8'h2C);
    check_val("baud_regh", uart_baud_regh, 8'h1B);

    // Single request with exact latency
    reset_dut();
    expect_tx(3'd0, 8'hA5);
    req_valid     = 4'b0001;
    req_data[7:0] = 8'hA5;
    req_last      = 4'b0001;
    check_val("lat_c0_ready", req_ready, 0);
    @(posedge clk); #1;
    check_val("lat_c1_grant", {grant_valid, grant_id}, {1'b1, 3'd0});
    check_val("lat_c1_ready", req_ready, 4'b0001);
    check_val("lat_c1_tx_on", uart_tx_on, 0);
    @(posedge clk); #1;
    req_valid = '0;
    req_last  = '0;
    check_val("lat_c2_tx_on", uart_tx_on, 1);
    check_val("lat_c2_tx_reg", uart_tx_reg, 8'hA5);
    check_val("lat_c2_ready", req_ready, 0);
    wait_release(100);
    // rr_ptr now 1: req1 must win over req0
    load(0, 8'hB0, 1'b1);
    load(1, 8'hB1, 1'b1);
    expect_tx(3'd1, 8'hB1);
    expect_tx(3'd0, 8'hB0);
    run_traffic(500);

    // Contention: order 0,1,2,3,0
    reset_dut();
    load(0, 8'h10, 1'b1);
    load(0, 8'h14, 1'b1);
    load(1, 8'h11, 1'b1);
    load(2, 8'h12, 1'b1);
    load(3, 8'h13, 1'b1);
    expect_tx(3'd0, 8'h10);
    expect_tx(3'd1, 8'h11);
    expect_tx(3'd2, 8'h12);
    expect_tx(3'd3, 8'h13);
    expect_tx(3'd0, 8'h14);
    run_traffic(1000);

    // Packet lock: req1 keeps the UART over a waiting req2
    reset_dut();
    load(1, 8'h11, 1'b0);
    load(1, 8'h22, 1'b0);
    load(1, 8'h33, 1'b1);
    load(2, 8'h44, 1'b1);
    expect_tx(3'd1, 8'h11);
    expect_tx(3'd1, 8'h22);
    expect_tx(3'd1, 8'h33);
    expect_tx(3'd2, 8'h44);
    run_traffic(1000);

    // MAX_PKT split: 4 bytes of req0, req1, then req0 resumes (tail times out)
    reset_dut();
    for (int k = 1; k <= 6; k++) load(0, 8'(k), 1'b0);
    load(1, 8'hA1, 1'b1);
    for (int k = 1; k <= 4; k++) expect_tx(3'd0, 8'(k));
    expect_tx(3'd1, 8'hA1);
    expect_tx(3'd0, 8'h05);
    expect_tx(3'd0, 8'h06);
    rise0 = abort_rise;
    run_traffic(2000);
    check_val("maxpkt_abort", 32'(abort_rise - rise0), 1);

    // Hold timeout on req3
    reset_dut();
    load(3, 8'h3C, 1'b0);
    expect_tx(3'd3, 8'h3C);
    idle0 = idle_cnt;
    rise0 = abort_rise;
    hi0   = abort_hi;
    run_traffic(2000);
    check_val("hold_idle_cycles", 32'(idle_cnt - idle0), HOLD_TO);
    check_val("hold_abort_rise", 32'(abort_rise - rise0), 1);
    check_val("hold_abort_width", 32'(abort_hi - hi0), 1);
    check_val("hold_grant_valid", grant_valid, 0);
    // rr_ptr wrapped to 0: req0 before req3
    load(3, 8'h3D, 1'b1);
    load(0, 8'h0D, 1'b1);
    expect_tx(3'd0, 8'h0D);
    expect_tx(3'd3, 8'h3D);
    run_traffic(500);

    // Reset while the UART is busy with req2's frame
    reset_dut();
    expect_tx(3'd2, 8'h77);
    req_valid      = 4'b0100;
    req_data[23:16] = 8'h77;
    req_last       = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #3;
    check_val("pre_rst_grant", {grant_valid, grant_id}, {1'b1, 3'd2});
    rise0 = abort_rise;
    resetn = 1'b0;
    #1;
    check_val("mid_rst_grant_valid", grant_valid, 0);
    check_val("mid_rst_grant_id", grant_id, 0);
    check_val("mid_rst_ready", req_ready, 0);
    check_val("mid_rst_tx_on", uart_tx_on, 0);
    check_val("mid_rst_tx_reg", uart_tx_reg, 8'h00);
    check_val("mid_rst_abort", pkt_abort, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (HOLD_TO + 20) @(posedge clk);
    #1;
    check_val("post_rst_no_abort", 32'(abort_rise - rise0), 0);
    check_val("post_rst_grant", grant_valid, 0);
    check_val("post_rst_sb", 32'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter BAUD_DIV, default 16'd434: clocks per bit driven to the UART.
REQ-003 SHALL have parameter MAX_PKT, default 16: max bytes per grant, range 1..255.
REQ-004 SHALL have parameter HOLD_TO, default 64: idle cycles tolerated mid-packet before forced release.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on posedge.
REQ-006 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  in  NREQ  per-requester byte valid.
REQ-008 SHALL have port req_data  in  8*NREQ  per-requester byte, requester i at bits [8i+7:8i].
REQ-009 SHALL have port req_last  in  NREQ  byte is last of packet, qualified by valid.
REQ-010 SHALL have port req_ready  out  NREQ  byte accepted when valid&ready.
REQ-011 SHALL have port grant_valid  out  1  a requester holds the UART.
REQ-012 SHALL have port grant_id  out  3  index of the current holder.
REQ-013 SHALL have port pkt_abort  out  1  one-cycle pulse on hold-timeout release.
REQ-014 SHALL have port uart_tx_reg  out  8  byte to UART.
REQ-015 SHALL have port uart_tx_on  out  1  one-cycle transmit strobe to UART.
REQ-016 SHALL have port uart_tx_busy  in  1  high while the UART shifts a frame.
REQ-017 SHALL have ports uart_baud_regl and uart_baud_regh  out  8 each  BAUD_DIV[7:0] and BAUD_DIV[15:8], constant.

Function
REQ-018 SHALL implement states IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: if any req_valid, SHALL pick the first valid index at or after rr_ptr (wrapping mod NREQ), set grant_id and grant_valid=1, clear byte count and hold count, and go to SEND next cycle.
REQ-020 SEND: req_ready SHALL be high only on bit grant_id; all other bits and all other states SHALL drive 0 (combinational from state/grant).
REQ-021 SEND with req_valid[grant_id]=1: SHALL latch the byte into uart_tx_reg, record req_last, increment the byte count, pulse uart_tx_on in the next cycle only, and go to WAIT_BUSY.
REQ-022 Latency: requester valid in IDLE at cycle 0 -> ready at cycle 1 -> uart_tx_on at cycle 2.
REQ-023 WAIT_BUSY SHALL go to WAIT_DONE on the first cycle uart_tx_busy=1; WAIT_DONE SHALL wait for uart_tx_busy=0.
REQ-024 On exit from WAIT_DONE: if the recorded last=1 or byte count==MAX_PKT, SHALL release. Release means grant_valid=0, rr_ptr=(grant_id+1) mod NREQ, go to IDLE. Otherwise SHALL return to SEND with the grant kept.
REQ-025 SEND with req_valid[grant_id]=0: SHALL increment the hold count. At HOLD_TO it SHALL release as in REQ-024 and pulse pkt_abort for one cycle.
REQ-026 The hold count SHALL clear on every accepted byte.
REQ-027 Changes in non-granted req_valid SHALL NOT affect a held grant. Arbitration SHALL occur only in IDLE.
REQ-028 A release and a new request in the same cycle SHALL NOT grant in that cycle; arbitration SHALL occur in the IDLE cycle that follows.
REQ-029 uart_tx_reg SHALL hold its value until the next accepted byte.
REQ-030 Counter widths SHALL be $clog2(MAX_PKT+1) and $clog2(HOLD_TO+1); counters SHALL NOT wrap.

Reset
REQ-031 On resetn=0, state, counters and outputs SHALL clear asynchronously: state=IDLE, rr_ptr=0, grant_valid=0, grant_id=0, pkt_abort=0, uart_tx_on=0, uart_tx_reg=8'h00, req_ready=0.
REQ-032 Reset mid-frame SHALL drop the packet without a pkt_abort pulse.
REQ-033 After reset deassertion, the first arbitration SHALL favour index 0.

Structure
REQ-034 Shared package uart_arb_pkg SHALL hold the state enum and the default NREQ, MAX_PKT and HOLD_TO constants.
REQ-035 Round-robin selection SHALL be a sub-module rr_pick: combinational, with inputs req vector and rr_ptr, and outputs found and index.

Verification
REQ-036 Single request: req0 sends 8'hA5 with last=1 -> uart_tx_on pulse at cycle 2 with uart_tx_reg=A5, then grant_valid=0 after busy falls, and rr_ptr=1.
REQ-037 Contention: req0..req3 all valid with single-byte packets -> grant order 0,1,2,3,0.
REQ-038 Packet lock: req1 sends 3 bytes 11,22,33 (last on 33) while req2 is valid -> all three bytes go out before req2 is granted.
REQ-039 MAX_PKT=4: req0 sends 6 bytes with no last -> release after 4 bytes, req1 served, then req0 resumes with byte 5.
REQ-040 Hold timeout: req3 drops valid after 1 byte without last -> pkt_abort at hold count 64, grant_valid=0, rr_ptr=0.
REQ-041 Reset during WAIT_DONE -> all outputs at reset values in the same cycle, and no pkt_abort.
